// File: rtl/riscv_pkg.sv
// Shared core-wide widths and defaults for the writeback path.
// Also holds the result-entry layout used between the arbiter and its FIFO.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int FIFO_DEPTH = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // x0 is hardwired to zero, so results aimed at it never reach the file
    function automatic logic rd_writes(input reg_addr_t rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small in-order result buffer with full/empty flags.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = REG_ADDR_W + XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and buffered long-latency results
// into one registered register-file write port, with a pending scoreboard.
module writeback_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int FIFO_DEPTH = riscv_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [XLEN-1:0]       rf_write_data
);

    localparam int ENTRY_W = REG_ADDR_W + XLEN;

    logic [ENTRY_W-1:0]    fifo_head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  alu_accept;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_reg_q, rf_reg_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    assign lsu_ready  = !fifo_full;
    assign alu_stall  = fifo_full;
    assign fifo_push  = lsu_valid && lsu_ready;
    assign alu_accept = alu_valid && !fifo_full;

    // Full forces a drain; otherwise the FIFO only uses ALU-idle slots
    assign fifo_pop = fifo_full || (!alu_valid && !fifo_empty);

    assign head_rd   = fifo_head[XLEN +: REG_ADDR_W];
    assign head_data = fifo_head[XLEN-1:0];

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ({lsu_rd, lsu_data}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        rf_we_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;
        if (alu_accept) begin
            if (rd_writes(alu_rd)) begin
                rf_we_d   = 1'b1;
                rf_reg_d  = alu_rd;
                rf_data_d = alu_data;
            end
        end else if (fifo_pop) begin
            if (rd_writes(head_rd)) begin
                rf_we_d   = 1'b1;
                rf_reg_d  = head_rd;
                rf_data_d = head_data;
            end
        end
    end

    // A fresh issue outranks the completion of an older op to the same rd
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
            pending_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
            pending_q <= pending_d;
        end
    end

    assign rf_write_enable = rf_we_q;
    assign rf_write_reg    = rf_reg_q;
    assign rf_write_data   = rf_data_q;

    assign rs1_busy = pending_q[rs1_addr]
                   || (rf_we_q && rf_reg_q == rs1_addr
                       && rs1_addr != '0);
    assign rs2_busy = pending_q[rs2_addr]
                   || (rf_we_q && rf_reg_q == rs2_addr
                       && rs2_addr != '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: ALU vector table plus
// scoreboarded multi-cycle sequences for buffering, hazards and reset.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;

    writeback_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_stall       (alu_stall),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        alu_valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   sb_on  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (rf_write_enable) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_extra: got write rd %0d data %0h expected none",
                         rf_write_reg, rf_write_data);
            end else begin
                e = sb_q.pop_front();
                chk("sb_rd", 64'(rf_write_reg), 64'(e.rd));
                chk("sb_data", 64'(rf_write_data), 64'(e.data));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (sb_on) sb_check();
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd5,  32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd6,  32'h0BAD0BAD, 1'b0, 5'd5,  32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
        vecs[5] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd1,  32'h00000000};

        idle_inputs();
        rs1_addr = '0;
        rs2_addr = '0;
        reset    = 1'b0;
        step();
        step();
        chk("rst_we", 64'(rf_write_enable), 64'd0);
        chk("rst_reg", 64'(rf_write_reg), 64'd0);
        chk("rst_data", 64'(rf_write_data), 64'd0);
        chk("rst_ready", 64'(lsu_ready), 64'd1);
        chk("rst_stall", 64'(alu_stall), 64'd0);
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        #1;
        chk("rst_busy1", 64'(rs1_busy), 64'd0);
        chk("rst_busy2", 64'(rs2_busy), 64'd0);
        reset = 1'b1;
        step();

        // ALU-only vectors, one per cycle
        for (int i = 0; i < 6; i++) begin
            alu_valid = vecs[i].alu_valid;
            alu_rd    = vecs[i].rd;
            alu_data  = vecs[i].data;
            step();
            chk($sformatf("vec%0d_we", i), 64'(rf_write_enable),
                64'(vecs[i].exp_we));
            chk($sformatf("vec%0d_reg", i), 64'(rf_write_reg),
                64'(vecs[i].exp_reg));
            chk($sformatf("vec%0d_data", i), 64'(rf_write_data),
                64'(vecs[i].exp_data));
        end
        idle_inputs();
        step();

        sb_on = 1'b1;

        // ALU and LSU together: ALU first, LSU on the next idle cycle
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
        #1;
        chk("both_ready", 64'(lsu_ready), 64'd1);
        expect_wr(5'd3, 32'hA);
        step();
        idle_inputs();
        expect_wr(5'd7, 32'h11);
        step();
        step();
        step();
        chk("both_q", 64'(sb_q.size()), 64'd0);

        // Three LSU pushes with ALU busy every cycle
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h111;
        #1;
        chk("f_ready0", 64'(lsu_ready), 64'd1);
        expect_wr(5'd10, 32'h100);
        step();
        alu_rd = 5'd12; alu_data = 32'h200;
        lsu_rd = 5'd13; lsu_data = 32'h113;
        #1;
        chk("f_ready1", 64'(lsu_ready), 64'd1);
        expect_wr(5'd12, 32'h200);
        step();
        alu_rd = 5'd14; alu_data = 32'h300;
        lsu_rd = 5'd15; lsu_data = 32'h115;
        #1;
        chk("f_ready2", 64'(lsu_ready), 64'd0);
        chk("f_stall2", 64'(alu_stall), 64'd1);
        expect_wr(5'd11, 32'h111);
        step();
        #1;
        chk("f_ready3", 64'(lsu_ready), 64'd1);
        chk("f_stall3", 64'(alu_stall), 64'd0);
        expect_wr(5'd14, 32'h300);
        step();
        idle_inputs();
        #1;
        chk("f_ready4", 64'(lsu_ready), 64'd0);
        chk("f_stall4", 64'(alu_stall), 64'd1);
        expect_wr(5'd13, 32'h113);
        step();
        expect_wr(5'd15, 32'h115);
        step();
        step();
        chk("f_q", 64'(sb_q.size()), 64'd0);
        chk("f_ready_end", 64'(lsu_ready), 64'd1);

        // Scoreboard hazard on rd 9
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b1; issue_rd = 5'd0;
        rs1_addr = 5'd9; rs2_addr = 5'd0;
        #1;
        chk("hz_busy1", 64'(rs1_busy), 64'd1);
        step();
        idle_inputs();
        #1;
        chk("hz_x0", 64'(rs2_busy), 64'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        expect_wr(5'd9, 32'h99);
        step();
        idle_inputs();
        #1;
        chk("hz_pend", 64'(rs1_busy), 64'd1);
        step();
        chk("hz_bypass", 64'(rs1_busy), 64'd1);
        step();
        chk("hz_clear", 64'(rs1_busy), 64'd0);

        // Issue to rd 9 in the same cycle its older result pops
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        idle_inputs();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h55;
        expect_wr(5'd9, 32'h55);
        step();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        idle_inputs();
        step();
        chk("set_wins", 64'(rs1_busy), 64'd1);

        // rd 0 result is consumed without a write
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFF;
        step();
        idle_inputs();
        step();
        chk("x0_we", 64'(rf_write_enable), 64'd0);
        chk("x0_pend", 64'(rs1_busy), 64'd1);
        chk("x0_ready", 64'(lsu_ready), 64'd1);
        step();
        chk("x0_q", 64'(sb_q.size()), 64'd0);

        // Reset with a full FIFO and pending bits
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h2121;
        issue_valid = 1'b1; issue_rd = 5'd17;
        expect_wr(5'd20, 32'h2020);
        step();
        issue_valid = 1'b0;
        alu_rd = 5'd22; alu_data = 32'h2222;
        lsu_rd = 5'd23; lsu_data = 32'h2323;
        expect_wr(5'd22, 32'h2222);
        step();
        idle_inputs();
        rs1_addr = 5'd17;
        #1;
        chk("pre_rst_ready", 64'(lsu_ready), 64'd0);
        chk("pre_rst_busy", 64'(rs1_busy), 64'd1);
        reset = 1'b0;
        step();
        chk("mr_we", 64'(rf_write_enable), 64'd0);
        chk("mr_reg", 64'(rf_write_reg), 64'd0);
        chk("mr_data", 64'(rf_write_data), 64'd0);
        chk("mr_ready", 64'(lsu_ready), 64'd1);
        chk("mr_stall", 64'(alu_stall), 64'd0);
        chk("mr_busy1", 64'(rs1_busy), 64'd0);
        chk("mr_busy2", 64'(rs2_busy), 64'd0);
        reset = 1'b1;
        step();
        chk("mr_nowr", 64'(rf_write_enable), 64'd0);
        step();
        chk("mr_q", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
